// File: rtl/dtack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtack_pkg
// Brief    : Shared types and constants for the 68000 DTACK/BERR generator:
//            decoded region, FSM state, counter widths and region priority.
// Revision : 1.0 - initial release
// ============================================================================
package dtack_pkg;

    localparam int c_WAIT_W    = 4;
    localparam int c_TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        REG_NONE     = 3'd0,
        REG_ROM      = 3'd1,
        REG_RAM      = 3'd2,
        REG_DRAM     = 3'd3,
        REG_IO       = 3'd4,
        REG_CAN      = 3'd5,
        REG_GFX      = 3'd6,
        REG_OFFBOARD = 3'd7
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_BERR = 2'd3
    } state_t;

    // Fixed priority so overlapping decoder selects always resolve the same way.
    function automatic region_t decodeRegion(
        input logic rom,
        input logic ram,
        input logic dram,
        input logic io,
        input logic can,
        input logic gfxL,
        input logic offBoard
    );
        if (rom)           return REG_ROM;
        else if (ram)      return REG_RAM;
        else if (dram)     return REG_DRAM;
        else if (io)       return REG_IO;
        else if (can)      return REG_CAN;
        else if (!gfxL)    return REG_GFX;
        else if (offBoard) return REG_OFFBOARD;
        else               return REG_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtack_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : dtack_generator_if
// Brief    : CPU strobes, decoder selects, device acknowledges and the
//            DTACK/BERR outputs of the acknowledge stage.
// Revision : 1.0 - initial release
// ============================================================================
interface dtack_generator_if;

    logic AS_L;
    logic UDS_L;
    logic LDS_L;
    logic OnChipRomSelect_H;
    logic OnChipRamSelect_H;
    logic DramSelect_H;
    logic IOSelect_H;
    logic CanBusSelect_H;
    logic GraphicsCS_L;
    logic OffBoardMemory_H;
    logic DramDtack_L;
    logic OffBoardDtack_L;
    logic DtAck_L;
    logic BusError_L;
    logic CycleActive_H;

    // CPU/decoder side drives strobes and selects, observes the acknowledges.
    modport master (
        output AS_L, UDS_L, LDS_L,
        output OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
        output IOSelect_H, CanBusSelect_H, GraphicsCS_L, OffBoardMemory_H,
        output DramDtack_L, OffBoardDtack_L,
        input  DtAck_L, BusError_L, CycleActive_H
    );

    // The acknowledge generator itself.
    modport slave (
        input  AS_L, UDS_L, LDS_L,
        input  OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
        input  IOSelect_H, CanBusSelect_H, GraphicsCS_L, OffBoardMemory_H,
        input  DramDtack_L, OffBoardDtack_L,
        output DtAck_L, BusError_L, CycleActive_H
    );

endinterface
`default_nettype wire

// File: rtl/dtack_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : dtack_timeout_counter
// Brief    : 16-bit clear/enable cycle counter flagging the last cycle before
//            a bus cycle is declared hung.
// Revision : 1.0 - initial release
// ============================================================================
module dtack_timeout_counter
    import dtack_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_terminal
);

    localparam logic [c_TIMEOUT_W-1:0] c_TERMINAL = c_TIMEOUT_W'(TIMEOUT - 1);

    logic [c_TIMEOUT_W-1:0] r_count;

    // Count cycles spent waiting; clear takes precedence over counting.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/dtack_generator.sv
`default_nettype none
// ============================================================================
// Module   : dtack_generator
// Brief    : 68000 bus-cycle acknowledge stage. Inserts fixed wait states for
//            on-chip/I/O regions, forwards DRAM and off-board acknowledges,
//            and raises bus error on unmapped or hung cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dtack_generator
    import dtack_pkg::*;
#(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0,
    parameter int IO_WAIT  = 2,
    parameter int CAN_WAIT = 4,
    parameter int GFX_WAIT = 3,
    parameter int TIMEOUT  = 1023
) (
    input  wire logic         Clock,
    input  wire logic         Reset_H,
    dtack_generator_if.slave  bus
);

    state_t                r_state;
    state_t                w_nextState;
    region_t               r_region;
    region_t               w_startRegion;
    logic [c_WAIT_W-1:0]   r_waitCnt;
    logic [c_WAIT_W-1:0]   w_startWait;
    logic                  w_start;
    logic                  w_ackCond;
    logic                  w_timeoutHit;
    logic                  r_dtackL;
    logic                  r_berrL;
    logic                  r_active;

    assign w_start       = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);
    assign w_startRegion = decodeRegion(bus.OnChipRomSelect_H, bus.OnChipRamSelect_H,
                                        bus.DramSelect_H, bus.IOSelect_H,
                                        bus.CanBusSelect_H, bus.GraphicsCS_L,
                                        bus.OffBoardMemory_H);

    // Wait-state load value for the region being opened; external-ack regions load zero.
    always_comb begin
        w_startWait = '0;
        case (w_startRegion)
            REG_ROM: w_startWait = c_WAIT_W'(ROM_WAIT);
            REG_RAM: w_startWait = c_WAIT_W'(RAM_WAIT);
            REG_IO:  w_startWait = c_WAIT_W'(IO_WAIT);
            REG_CAN: w_startWait = c_WAIT_W'(CAN_WAIT);
            REG_GFX: w_startWait = c_WAIT_W'(GFX_WAIT);
            default: w_startWait = '0;
        endcase
    end

    // Acknowledge condition for the latched region while waiting.
    always_comb begin
        w_ackCond = 1'b0;
        case (r_region)
            REG_DRAM:     w_ackCond = !bus.DramDtack_L;
            REG_OFFBOARD: w_ackCond = !bus.OffBoardDtack_L;
            REG_NONE:     w_ackCond = 1'b0;
            default:      w_ackCond = (r_waitCnt == '0);
        endcase
    end

    dtack_timeout_counter #(
        .TIMEOUT    (TIMEOUT)
    ) u_timeout (
        .clk        (Clock),
        .rst        (Reset_H),
        .i_clear    (r_state == ST_IDLE),
        .i_enable   (r_state == ST_WAIT),
        .o_terminal (w_timeoutHit)
    );

    // Next-state logic: abort beats ack, ack beats timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_nextState = ST_WAIT;
            ST_WAIT: begin
                if (bus.AS_L)          w_nextState = ST_IDLE;
                else if (w_ackCond)    w_nextState = ST_ACK;
                else if (w_timeoutHit) w_nextState = ST_BERR;
            end
            ST_ACK:  if (bus.AS_L) w_nextState = ST_IDLE;
            ST_BERR: if (bus.AS_L) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_state  <= ST_IDLE;
            r_dtackL <= 1'b1;
            r_berrL  <= 1'b1;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_dtackL <= (w_nextState != ST_ACK);
            r_berrL  <= (w_nextState != ST_BERR);
            r_active <= (w_nextState != ST_IDLE);
        end
    end

    // Region latched once at cycle start; wait counter loaded then counted down.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_region  <= REG_NONE;
            r_waitCnt <= '0;
        end else if (r_state == ST_IDLE && w_start) begin
            r_region  <= w_startRegion;
            r_waitCnt <= w_startWait;
        end else if (r_state == ST_WAIT && r_waitCnt != '0) begin
            r_waitCnt <= r_waitCnt - 1'b1;
        end
    end

    assign bus.DtAck_L       = r_dtackL;
    assign bus.BusError_L    = r_berrL;
    assign bus.CycleActive_H = r_active;

endmodule
`default_nettype wire

// File: tb/tb_dtack_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtack_generator
// Brief    : Directed self-checking bench for dtack_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtack_generator;

    logic Clock;
    logic Reset_H;
    int   nErr;
    int   nChk;

    dtack_generator_if bus();

    dtack_generator #(
        .ROM_WAIT (1),
        .RAM_WAIT (0),
        .IO_WAIT  (5),
        .CAN_WAIT (4),
        .GFX_WAIT (3),
        .TIMEOUT  (16)
    ) dut (
        .Clock    (Clock),
        .Reset_H  (Reset_H),
        .bus      (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        nChk++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clearSelects();
        bus.OnChipRomSelect_H = 1'b0;
        bus.OnChipRamSelect_H = 1'b0;
        bus.DramSelect_H      = 1'b0;
        bus.IOSelect_H        = 1'b0;
        bus.CanBusSelect_H    = 1'b0;
        bus.GraphicsCS_L      = 1'b1;
        bus.OffBoardMemory_H  = 1'b0;
    endtask

    task automatic strobes(input logic low);
        bus.AS_L  = !low;
        bus.UDS_L = !low;
        bus.LDS_L = !low;
    endtask

    initial begin
        nErr = 0;
        nChk = 0;
        Reset_H = 1'b1;
        strobes(1'b0);
        clearSelects();
        bus.DramDtack_L     = 1'b1;
        bus.OffBoardDtack_L = 1'b1;
        tick();
        tick();
        Reset_H = 1'b0;
        chk("reset_dtack", bus.DtAck_L, 1'b1);
        chk("reset_berr", bus.BusError_L, 1'b1);
        chk("reset_active", bus.CycleActive_H, 1'b0);
        tick();

        // ROM, wait 1: ack after N+2.
        bus.OnChipRomSelect_H = 1'b1;
        strobes(1'b1);
        tick();
        chk("rom_n_active", bus.CycleActive_H, 1'b1);
        chk("rom_n_dtack", bus.DtAck_L, 1'b1);
        tick();
        chk("rom_n1_dtack", bus.DtAck_L, 1'b1);
        tick();
        chk("rom_n2_dtack", bus.DtAck_L, 0);
        chk("rom_n2_berr", bus.BusError_L, 1'b1);
        tick();
        chk("rom_hold_dtack", bus.DtAck_L, 1'b0);
        strobes(1'b0);
        clearSelects();
        tick();
        chk("rom_end_dtack", bus.DtAck_L, 1'b1);
        chk("rom_end_active", bus.CycleActive_H, 1'b0);
        tick();

        // RAM, wait 0, selects changed during WAIT.
        bus.OnChipRamSelect_H = 1'b1;
        strobes(1'b1);
        tick();
        chk("ram_n_dtack", bus.DtAck_L, 1'b1);
        bus.OnChipRamSelect_H = 1'b0;
        bus.IOSelect_H        = 1'b1;
        tick();
        chk("ram_n1_dtack", bus.DtAck_L, 1'b0);
        strobes(1'b0);
        clearSelects();
        tick();
        chk("ram_end_dtack", bus.DtAck_L, 1'b1);
        tick();

        // DRAM, device ack sampled at N+7.
        bus.DramSelect_H = 1'b1;
        strobes(1'b1);
        tick();
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("dram_wait_dtack", bus.DtAck_L, 1'b1);
            chk("dram_wait_active", bus.CycleActive_H, 1'b1);
        end
        bus.DramDtack_L = 1'b0;
        tick();
        chk("dram_ack_dtack", bus.DtAck_L, 1'b0);
        chk("dram_ack_active", bus.CycleActive_H, 1'b1);
        strobes(1'b0);
        bus.DramDtack_L = 1'b1;
        clearSelects();
        tick();
        chk("dram_end_dtack", bus.DtAck_L, 1'b1);
        chk("dram_end_active", bus.CycleActive_H, 1'b0);
        tick();

        // Unmapped: bus error after N+16.
        strobes(1'b1);
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("none_wait_berr", bus.BusError_L, 1'b1);
        end
        tick();
        chk("none_to_berr", bus.BusError_L, 1'b0);
        chk("none_to_dtack", bus.DtAck_L, 1'b1);
        tick();
        chk("none_hold_berr", bus.BusError_L, 1'b0);
        strobes(1'b0);
        tick();
        chk("none_end_berr", bus.BusError_L, 1'b1);
        chk("none_end_dtack", bus.DtAck_L, 1'b1);
        tick();

        // DRAM ack arriving in the timeout cycle wins.
        bus.DramSelect_H = 1'b1;
        strobes(1'b1);
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("race_wait_berr", bus.BusError_L, 1'b1);
        end
        bus.DramDtack_L = 1'b0;
        tick();
        chk("race_dtack", bus.DtAck_L, 1'b0);
        chk("race_berr", bus.BusError_L, 1'b1);
        strobes(1'b0);
        bus.DramDtack_L = 1'b1;
        clearSelects();
        tick();
        chk("race_end_dtack", bus.DtAck_L, 1'b1);
        tick();

        // IO abort after 2 wait cycles, then a normal IO cycle (ack after N+6).
        bus.IOSelect_H = 1'b1;
        strobes(1'b1);
        tick();
        tick();
        tick();
        strobes(1'b0);
        tick();
        chk("abort_active", bus.CycleActive_H, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("abort_dtack", bus.DtAck_L, 1'b1);
            chk("abort_berr", bus.BusError_L, 1'b1);
            tick();
        end
        strobes(1'b1);
        tick();
        chk("io_n_active", bus.CycleActive_H, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("io_wait_dtack", bus.DtAck_L, 1'b1);
        end
        tick();
        chk("io_ack_dtack", bus.DtAck_L, 1'b0);
        strobes(1'b0);
        clearSelects();
        tick();
        chk("io_end_dtack", bus.DtAck_L, 1'b1);
        tick();

        // Reset during ACK with AS_L still low, then a fresh ROM cycle.
        bus.OnChipRomSelect_H = 1'b1;
        strobes(1'b1);
        tick();
        tick();
        tick();
        chk("rst_pre_dtack", bus.DtAck_L, 1'b0);
        Reset_H = 1'b1;
        tick();
        chk("rst_dtack", bus.DtAck_L, 1'b1);
        chk("rst_active", bus.CycleActive_H, 1'b0);
        Reset_H = 1'b0;
        tick();
        chk("rst_restart_active", bus.CycleActive_H, 1'b1);
        chk("rst_restart_dtack", bus.DtAck_L, 1'b1);
        tick();
        chk("rst_n1_dtack", bus.DtAck_L, 1'b1);
        tick();
        chk("rst_n2_dtack", bus.DtAck_L, 1'b0);
        strobes(1'b0);
        clearSelects();
        tick();
        chk("rst_end_dtack", bus.DtAck_L, 1'b1);
        chk("rst_end_active", bus.CycleActive_H, 1'b0);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
`default_nettype wire
